spi_sub: RTL and testbench

//  SPI subordinate (target) end of the link driven by our SPI main: receives SCLK/CS_n/MOSI

---
 rtl/spi_sub_if.sv | 26 ++
 rtl/spi_sub.sv | 194 +++++++++++++++++++
 tb/tb_spi_sub.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sub_if.sv
// Pin and fabric-side signal bundle for the SPI subordinate.
// The master modport is the side that drives SCLK/CS_n/MOSI and offers TX bytes.
interface spi_sub_if;
    logic [7:0] i_tx_byte;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic       o_tx_underrun;
    logic [7:0] o_rx_byte;
    logic       o_rx_valid;
    logic       o_abort;
    logic       i_spi_clk;
    logic       i_cs_n;
    logic       i_mosi;
    logic       o_miso;
    logic       o_miso_oe;

    modport master (
        output i_tx_byte, i_tx_valid, i_spi_clk, i_cs_n, i_mosi,
        input  o_tx_ready, o_tx_underrun, o_rx_byte, o_rx_valid, o_abort, o_miso, o_miso_oe
    );

    modport slave (
        input  i_tx_byte, i_tx_valid, i_spi_clk, i_cs_n, i_mosi,
        output o_tx_ready, o_tx_underrun, o_rx_byte, o_rx_valid, o_abort, o_miso, o_miso_oe
    );
endinterface

// File: rtl/spi_sub.sv
// SPI subordinate, modes 0-3, LSB first, 8-bit frames; SPI pins are oversampled in i_clk.
//  state  | meaning
//  IDLE   | CS_n high (synced); mode follows i_mode, waiting for CS_n fall
//  ACTIVE | frame in progress; SCLK edges shift MISO out and MOSI in
module spi_sub #(
    parameter logic [7:0] DEFAULT_TX  = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_mode,
    spi_sub_if.slave   bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [1:0]             mode_q, mode_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_q, rx_d;
    logic [7:0]             hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   need_load_q, need_load_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   abort_q, abort_d;
    logic                   miso_q, miso_d;

    logic       sclk_s, cs_s, mosi_s;
    logic       cs_fall, sclk_rise, sclk_fall, lead, trail;
    logic       load, done;
    logic [7:0] load_byte, rx_next;
    logic [2:0] bit_nxt;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign lead      = mode_q[1] ? sclk_fall : sclk_rise;
    assign trail     = mode_q[1] ? sclk_rise : sclk_fall;
    assign load_byte = hold_full_q ? hold_q : DEFAULT_TX;
    assign bit_nxt   = bit_cnt_q + 3'd1;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.i_spi_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.i_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.i_mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        state_d     = state_q;
        mode_d      = mode_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_d        = rx_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        need_load_d = need_load_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        miso_d      = miso_q;
        load        = 1'b0;
        done        = 1'b0;
        rx_next     = rx_q;
        rx_next[bit_cnt_q] = mosi_s;

        case (state_q)
            IDLE: begin
                if (cs_s) begin
                    mode_d = i_mode;
                end else if (cs_fall) begin
                    state_d     = ACTIVE;
                    load        = 1'b1;
                    shift_d     = load_byte;
                    bit_cnt_d   = 3'd0;
                    need_load_d = 1'b0;
                    rx_d        = 8'h00;
                    miso_d      = mode_q[0] ? 1'b0 : load_byte[0];
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    // Partial bytes are dropped; the holding register is untouched.
                    state_d = IDLE;
                    abort_d = (bit_cnt_q != 3'd0);
                    miso_d  = 1'b0;
                end else if (lead) begin
                    if (!mode_q[0]) begin
                        rx_d = rx_next;
                        done = (bit_cnt_q == 3'd7);
                    end else if (need_load_q) begin
                        load        = 1'b1;
                        shift_d     = load_byte;
                        miso_d      = load_byte[0];
                        need_load_d = 1'b0;
                    end else begin
                        miso_d = shift_q[bit_cnt_q];
                    end
                end else if (trail) begin
                    if (!mode_q[0]) begin
                        bit_cnt_d = bit_nxt;
                        if (bit_cnt_q == 3'd7) begin
                            load    = 1'b1;
                            shift_d = load_byte;
                            miso_d  = load_byte[0];
                        end else begin
                            miso_d = shift_q[bit_nxt];
                        end
                    end else begin
                        rx_d      = rx_next;
                        done      = (bit_cnt_q == 3'd7);
                        bit_cnt_d = bit_nxt;
                        if (bit_cnt_q == 3'd7) need_load_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            rx_byte_d  = rx_next;
            rx_valid_d = 1'b1;
        end

        // A write in the same cycle as a load only fills holding for the following byte.
        if (load) begin
            if (hold_full_q) hold_full_d = 1'b0;
            else             underrun_d  = 1'b1;
        end
        if (bus.i_tx_valid && !hold_full_q) begin
            hold_d      = bus.i_tx_byte;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            mode_q      <= 2'b00;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_q        <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            need_load_q <= 1'b0;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            mode_q      <= mode_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            need_load_q <= need_load_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
            miso_q      <= miso_d;
        end
    end

    assign bus.o_tx_ready    = ~hold_full_q;
    assign bus.o_tx_underrun = underrun_q;
    assign bus.o_rx_byte     = rx_byte_q;
    assign bus.o_rx_valid    = rx_valid_q;
    assign bus.o_abort       = abort_q;
    assign bus.o_miso        = miso_q;
    assign bus.o_miso_oe     = ~cs_s;
endmodule

// File: tb/tb_spi_sub.sv
// Directed bench for spi_sub: acts as SPI main and local fabric, checks with immediate assertions.
module tb_spi_sub;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [1:0] mode_in = 2'b00;
    logic [1:0] tb_mode = 2'b00;
    int         checks = 0;
    int         failures = 0;
    int         n_rx = 0, n_und = 0, n_abt = 0;
    int         rx0, und0, abt0;
    logic [7:0] rd;

    spi_sub_if bus ();

    spi_sub #(.DEFAULT_TX(8'h00), .SYNC_STAGES(2)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_mode(mode_in),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (bus.o_rx_valid)    n_rx  <= n_rx + 1;
        if (bus.o_tx_underrun) n_und <= n_und + 1;
        if (bus.o_abort)       n_abt <= n_abt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge i_clk);
    endtask

    task automatic set_mode(input logic [1:0] m);
        tb_mode = m;
        mode_in = m;
        bus.i_spi_clk = m[1];
        half();
    endtask

    task automatic tx_write(input logic [7:0] b);
        @(negedge i_clk);
        bus.i_tx_byte  = b;
        bus.i_tx_valid = 1'b1;
        @(negedge i_clk);
        bus.i_tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        bus.i_cs_n = 1'b0;
        half();
    endtask

    task automatic cs_high();
        bus.i_cs_n = 1'b1;
        half();
        half();
    endtask

    task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!tb_mode[0]) begin
                bus.i_mosi = b[i];
                half();
                bus.i_spi_clk = ~tb_mode[1];
                r[i] = bus.o_miso;
                half();
                bus.i_spi_clk = tb_mode[1];
            end else begin
                half();
                bus.i_spi_clk = ~tb_mode[1];
                bus.i_mosi = b[i];
                half();
                bus.i_spi_clk = tb_mode[1];
                r[i] = bus.o_miso;
            end
        end
        half();
    endtask

    initial begin
        bus.i_tx_byte  = 8'h00;
        bus.i_tx_valid = 1'b0;
        bus.i_spi_clk  = 1'b0;
        bus.i_cs_n     = 1'b1;
        bus.i_mosi     = 1'b0;
        repeat (4) @(negedge i_clk);
        check("rst_rx_byte", bus.o_rx_byte, 8'h00);
        check("rst_rx_valid", bus.o_rx_valid, 1'b0);
        check("rst_tx_ready", bus.o_tx_ready, 1'b1);
        check("rst_underrun", bus.o_tx_underrun, 1'b0);
        check("rst_abort", bus.o_abort, 1'b0);
        check("rst_miso", bus.o_miso, 1'b0);
        check("rst_miso_oe", bus.o_miso_oe, 1'b0);
        i_rst = 1'b0;
        half();

        // T1: mode 0 single byte
        set_mode(2'b00);
        tx_write(8'hA5);
        check("t1_tx_ready_full", bus.o_tx_ready, 1'b0);
        rx0 = n_rx; und0 = n_und;
        cs_low();
        check("t1_miso_oe", bus.o_miso_oe, 1'b1);
        check("t1_no_underrun", n_und - und0, 0);
        check("t1_tx_ready_empty", bus.o_tx_ready, 1'b1);
        xfer(8'h3C, 8, rd);
        check("t1_miso_byte", rd, 8'hA5);
        check("t1_rx_byte", bus.o_rx_byte, 8'h3C);
        check("t1_rx_count", n_rx - rx0, 1);
        cs_high();
        check("t1_oe_off", bus.o_miso_oe, 1'b0);

        // T2: modes 1..3
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1:0]);
            tx_write(8'h81);
            rx0 = n_rx;
            cs_low();
            xfer(8'h7E, 8, rd);
            check($sformatf("t2_m%0d_miso_byte", m), rd, 8'h81);
            check($sformatf("t2_m%0d_rx_byte", m), bus.o_rx_byte, 8'h7E);
            check($sformatf("t2_m%0d_rx_count", m), n_rx - rx0, 1);
            cs_high();
        end

        // T3: mode 0 burst, second TX byte written during byte 1, overwrite attempt ignored
        set_mode(2'b00);
        tx_write(8'h11);
        rx0 = n_rx;
        cs_low();
        tx_write(8'h22);
        check("t3_tx_ready_full", bus.o_tx_ready, 1'b0);
        tx_write(8'h99);
        xfer(8'hC3, 8, rd);
        check("t3_miso_byte1", rd, 8'h11);
        check("t3_rx_byte1", bus.o_rx_byte, 8'hC3);
        xfer(8'h5A, 8, rd);
        check("t3_miso_byte2", rd, 8'h22);
        check("t3_rx_byte2", bus.o_rx_byte, 8'h5A);
        check("t3_rx_count", n_rx - rx0, 2);
        cs_high();

        // T4: nothing loaded -> DEFAULT_TX and underrun at CS_n fall
        und0 = n_und;
        cs_low();
        check("t4_underrun_at_fall", n_und - und0, 1);
        xfer(8'hFF, 8, rd);
        check("t4_miso_byte", rd, 8'h00);
        check("t4_rx_byte", bus.o_rx_byte, 8'hFF);
        cs_high();

        // T5: abort after 3 bits, then a clean frame
        tx_write(8'h5A);
        rx0 = n_rx; abt0 = n_abt;
        cs_low();
        xfer(8'h07, 3, rd);
        cs_high();
        check("t5_abort_count", n_abt - abt0, 1);
        check("t5_no_rx_valid", n_rx - rx0, 0);
        check("t5_rx_byte_kept", bus.o_rx_byte, 8'hFF);
        tx_write(8'h96);
        cs_low();
        xfer(8'h69, 8, rd);
        check("t5_miso_after", rd, 8'h96);
        check("t5_rx_after", bus.o_rx_byte, 8'h69);
        check("t5_rx_count_after", n_rx - rx0, 1);
        cs_high();

        // T6: i_mode changed mid-frame has no effect until CS_n is high
        tx_write(8'h3E);
        cs_low();
        mode_in = 2'b11;
        xfer(8'hB1, 8, rd);
        check("t6_mode_hold_miso", rd, 8'h3E);
        check("t6_mode_hold_rx", bus.o_rx_byte, 8'hB1);
        mode_in = 2'b00;
        cs_high();

        // T6: reset mid-byte with CS_n still low
        cs_low();
        xfer(8'hF0, 4, rd);
        tx_write(8'h44);
        check("t6_tx_ready_before_rst", bus.o_tx_ready, 1'b0);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        check("t6_rst_rx_byte", bus.o_rx_byte, 8'h00);
        check("t6_rst_rx_valid", bus.o_rx_valid, 1'b0);
        check("t6_rst_tx_ready", bus.o_tx_ready, 1'b1);
        check("t6_rst_miso", bus.o_miso, 1'b0);
        check("t6_rst_miso_oe", bus.o_miso_oe, 1'b0);
        check("t6_rst_abort", bus.o_abort, 1'b0);
        check("t6_rst_underrun", bus.o_tx_underrun, 1'b0);
        bus.i_cs_n = 1'b1;
        bus.i_spi_clk = 1'b0;
        half();
        i_rst = 1'b0;
        half();
        tx_write(8'hC3);
        rx0 = n_rx;
        cs_low();
        xfer(8'h5A, 8, rd);
        check("t6_post_rst_miso", rd, 8'hC3);
        check("t6_post_rst_rx", bus.o_rx_byte, 8'h5A);
        check("t6_post_rst_count", n_rx - rx0, 1);
        cs_high();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
